// File: rtl/iir_tap_loader_pkg.sv
// Shared types and address helpers for the IIR tap loader.
// Shadow map: 0..G-1 hold b taps, G..2G-1 hold a taps.
package iir_tap_loader_pkg;

  typedef logic [31:0] float_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STREAM,
    ST_WAIT_DONE
  } state_t;

  function automatic int unsigned b_addr(
    input int unsigned i
  );
    return i;
  endfunction

  function automatic int unsigned a_addr(
    input int unsigned i,
    input int unsigned g
  );
    return g + i;
  endfunction

endpackage

// File: rtl/tap_stream_channel.sv
// One valid/ready tap stream: index counter, valid, data register, finished.
// Ports: start, abort, taps[], ready in; data, valid, finished out.
module tap_stream_channel
  import iir_tap_loader_pkg::*;
#(
  parameter int G_DEGREE = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   abort,
  input  float_t taps [G_DEGREE],
  input  logic   ready,
  output float_t data,
  output logic   valid,
  output logic   finished
);

  localparam int IW = (G_DEGREE > 1) ? $clog2(G_DEGREE) : 1;

  logic [IW-1:0] idx_q, idx_d;
  float_t        data_q, data_d;
  logic          valid_q, valid_d;
  logic          fin_q, fin_d;
  logic          last_hs;

  assign last_hs = valid_q && ready
                && (idx_q == IW'(G_DEGREE - 1));

  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    fin_d   = fin_q;
    if (abort) begin
      valid_d = 1'b0;
    end else if (start) begin
      idx_d   = '0;
      data_d  = taps[0];
      valid_d = 1'b1;
      fin_d   = 1'b0;
    end else if (last_hs) begin
      valid_d = 1'b0;
      fin_d   = 1'b1;
    end else if (valid_q && ready) begin
      idx_d  = idx_q + 1'b1;
      data_d = taps[idx_q + 1'b1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
    end
  end

  // Finishing counts on the final handshake edge itself.
  assign finished = fin_q || last_hs;
  assign data     = data_q;
  assign valid    = valid_q;

endmodule

// File: rtl/iir_tap_loader.sv
// Shadows b/a float32 taps, flushes the filter and streams both tap sets.
// Ports: cfg write/commit/status, iir_enable, b/a valid-ready-done streams.
// Optional readback port set: define IIR_TAP_LOADER_READBACK_EN.
module iir_tap_loader
  import iir_tap_loader_pkg::*;
#(
  parameter int G_DEGREE          = 3,
  parameter int ENABLE_LOW_CYCLES = 2,
  parameter int DONE_TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(2*G_DEGREE)-1:0] cfg_wr_addr,
  input  logic [31:0]                   cfg_wr_data,
  input  logic                          cfg_commit,
  output logic                          cfg_busy,
  output logic                          cfg_loaded,
  output logic                          cfg_wr_dropped,
  output logic                          load_error,
  output logic                          iir_enable,
  output logic [31:0]                   b_tap,
  output logic                          b_tap_valid,
  input  logic                          b_tap_ready,
  input  logic                          b_tap_done,
  output logic [31:0]                   a_tap,
  output logic                          a_tap_valid,
  input  logic                          a_tap_ready,
  input  logic                          a_tap_done
`ifdef IIR_TAP_LOADER_READBACK_EN
  ,
  input  logic                          cfg_rd_en,
  input  logic [$clog2(2*G_DEGREE)-1:0] cfg_rd_addr,
  output logic [31:0]                   cfg_rd_data,
  output logic                          cfg_rd_valid
`endif
);

  localparam int FW = $clog2(ENABLE_LOW_CYCLES + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pending_q, pending_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          loaded_q, loaded_d;
  logic          error_q, error_d;
  logic          dropped_q, dropped_d;
  float_t        shadow_b_q [G_DEGREE];
  float_t        shadow_b_d [G_DEGREE];
  float_t        shadow_a_q [G_DEGREE];
  float_t        shadow_a_d [G_DEGREE];
  logic          start;
  logic          timeout;
  logic          b_fin;
  logic          a_fin;

  assign start = (state_q == ST_FLUSH)
              && (flush_q == FW'(ENABLE_LOW_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    tmo_d      = tmo_q;
    pending_d  = pending_q;
    enable_d   = enable_q;
    busy_d     = busy_q;
    loaded_d   = loaded_q;
    error_d    = error_q;
    dropped_d  = dropped_q;
    shadow_b_d = shadow_b_q;
    shadow_a_d = shadow_a_q;
    timeout    = 1'b0;

    // Writes land before a same-cycle commit; the FSM streams later.
    if (cfg_wr_en) begin
      if (state_q == ST_IDLE) begin
        for (int i = 0; i < G_DEGREE; i++) begin
          if (32'(cfg_wr_addr) == b_addr(i))
            shadow_b_d[i] = cfg_wr_data;
          if (32'(cfg_wr_addr) == a_addr(i, G_DEGREE))
            shadow_a_d[i] = cfg_wr_data;
        end
      end else begin
        dropped_d = 1'b1;
      end
    end

    if (cfg_commit && (state_q != ST_IDLE))
      pending_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_commit || pending_q) begin
          state_d   = ST_FLUSH;
          flush_d   = '0;
          enable_d  = 1'b0;
          busy_d    = 1'b1;
          loaded_d  = 1'b0;
          error_d   = 1'b0;
          dropped_d = 1'b0;
          pending_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (start) begin
          state_d  = ST_STREAM;
          tmo_d    = '0;
          enable_d = 1'b1;
        end
      end
      ST_STREAM: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_d == TW'(DONE_TIMEOUT))
          timeout = 1'b1;
        else if (b_fin && a_fin)
          state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        if (b_tap_done && a_tap_done) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          loaded_d = 1'b1;
        end else if (tmo_d == TW'(DONE_TIMEOUT)) begin
          timeout = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d  = ST_IDLE;
      error_d  = 1'b1;
      enable_d = 1'b0;
      busy_d   = 1'b0;
      loaded_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      flush_q    <= '0;
      tmo_q      <= '0;
      pending_q  <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      error_q    <= 1'b0;
      dropped_q  <= 1'b0;
      shadow_b_q <= '{default: '0};
      shadow_a_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      tmo_q      <= tmo_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      error_q    <= error_d;
      dropped_q  <= dropped_d;
      shadow_b_q <= shadow_b_d;
      shadow_a_q <= shadow_a_d;
    end
  end

  tap_stream_channel #(.G_DEGREE(G_DEGREE)) u_b_chan (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (timeout),
    .taps     (shadow_b_q),
    .ready    (b_tap_ready),
    .data     (b_tap),
    .valid    (b_tap_valid),
    .finished (b_fin)
  );

  tap_stream_channel #(.G_DEGREE(G_DEGREE)) u_a_chan (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (timeout),
    .taps     (shadow_a_q),
    .ready    (a_tap_ready),
    .data     (a_tap),
    .valid    (a_tap_valid),
    .finished (a_fin)
  );

  assign cfg_busy       = busy_q;
  assign cfg_loaded     = loaded_q;
  assign cfg_wr_dropped = dropped_q;
  assign load_error     = error_q;
  assign iir_enable     = enable_q;

`ifdef IIR_TAP_LOADER_READBACK_EN
  float_t rd_data_q, rd_data_d;
  logic   rd_valid_q, rd_valid_d;

  // Reads see the pre-write shadow value.
  always_comb begin
    rd_valid_d = cfg_rd_en;
    rd_data_d  = rd_data_q;
    if (cfg_rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < G_DEGREE; i++) begin
        if (32'(cfg_rd_addr) == b_addr(i))
          rd_data_d = shadow_b_q[i];
        if (32'(cfg_rd_addr) == a_addr(i, G_DEGREE))
          rd_data_d = shadow_a_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign cfg_rd_data  = rd_data_q;
  assign cfg_rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_iir_tap_loader.sv
// Scoreboard bench for iir_tap_loader (G=3, 2 low cycles, timeout 8).
// Stimulus pushes expected taps; a negedge monitor pops on handshakes.
module tb_iir_tap_loader;
  import iir_tap_loader_pkg::*;

  localparam int G   = 3;
  localparam int L   = 2;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_wr_addr = '0;
  logic [31:0] cfg_wr_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_busy, cfg_loaded, cfg_wr_dropped;
  logic        load_error, iir_enable;
  logic [31:0] b_tap, a_tap;
  logic        b_tap_valid, a_tap_valid;
  logic        b_tap_ready = 1'b0, a_tap_ready = 1'b0;
  logic        b_tap_done = 1'b0, a_tap_done = 1'b0;

  always #5 clk = ~clk;

  iir_tap_loader #(
    .G_DEGREE(G), .ENABLE_LOW_CYCLES(L), .DONE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .cfg_loaded(cfg_loaded),
    .cfg_wr_dropped(cfg_wr_dropped), .load_error(load_error),
    .iir_enable(iir_enable),
    .b_tap(b_tap), .b_tap_valid(b_tap_valid),
    .b_tap_ready(b_tap_ready), .b_tap_done(b_tap_done),
    .a_tap(a_tap), .a_tap_valid(a_tap_valid),
    .a_tap_ready(a_tap_ready), .a_tap_done(a_tap_done)
  );

  int     errs = 0;
  int     checks = 0;
  float_t exp_b[$];
  float_t exp_a[$];
  float_t mdl_b [G];
  float_t mdl_a [G];
  int     b_hs = 0, a_hs = 0, b_wait = 0, a_wait = 0;
  int     b_delay = 2, a_delay = 2;
  bit     b_done_en = 1'b1, a_done_en = 1'b1;
  logic [7:0] b_pat = 8'hFF, a_pat = 8'hFF;
  int     b_pos = 0, a_pos = 0;
  int     since_stream = 0, flush_cyc = 0;
  logic   prev_en = 1'b0, prev_err = 1'b0;
  logic   b_stall = 1'b0, a_stall = 1'b0;
  time    b_last_t = 0, a_last_t = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ready responder: per-cycle pattern while valid is up.
  always @(posedge clk) begin
    #2;
    if (b_tap_valid) begin
      b_tap_ready = (b_pos < 8) ? b_pat[b_pos] : 1'b1;
      b_pos++;
    end else b_tap_ready = 1'b0;
    if (a_tap_valid) begin
      a_tap_ready = (a_pos < 8) ? a_pat[a_pos] : 1'b1;
      a_pos++;
    end else a_tap_ready = 1'b0;
  end

  // Monitor, scoreboard and done responder.
  always @(negedge clk) begin
    if (!reset) begin
      if (cfg_busy && !iir_enable) begin
        flush_cyc++;
        b_hs = 0; a_hs = 0; b_wait = 0; a_wait = 0;
        b_pos = 0; a_pos = 0; since_stream = 0;
      end
      if (cfg_busy && iir_enable) since_stream++;
      if (iir_enable && !prev_en && cfg_busy) begin
        chk("flush_len", flush_cyc, L);
        chk("start_b_valid", 32'(b_tap_valid), 1);
        chk("start_a_valid", 32'(a_tap_valid), 1);
        flush_cyc = 0;
      end
      if (b_stall) chk("b_valid_held", 32'(b_tap_valid), 1);
      if (a_stall) chk("a_valid_held", 32'(a_tap_valid), 1);
      if (b_tap_valid && b_tap_ready) begin
        if (exp_b.size() == 0) begin
          checks++; errs++;
          $display("FAIL b_extra: got %h expected none", b_tap);
        end else chk("b_tap", b_tap, exp_b.pop_front());
        b_hs++;
        if (b_hs == G) b_last_t = $time;
      end else if (b_tap_valid && exp_b.size() > 0)
        chk("b_hold", b_tap, exp_b[0]);
      if (a_tap_valid && a_tap_ready) begin
        if (exp_a.size() == 0) begin
          checks++; errs++;
          $display("FAIL a_extra: got %h expected none", a_tap);
        end else chk("a_tap", a_tap, exp_a.pop_front());
        a_hs++;
        if (a_hs == G) a_last_t = $time;
      end else if (a_tap_valid && exp_a.size() > 0)
        chk("a_hold", a_tap, exp_a[0]);
      if (load_error && !prev_err) begin
        chk("tmo_cycle", since_stream, TMO);
        chk("tmo_enable", 32'(iir_enable), 0);
        chk("tmo_loaded", 32'(cfg_loaded), 0);
        chk("tmo_busy", 32'(cfg_busy), 0);
        chk("tmo_valids", 32'({b_tap_valid, a_tap_valid}), 0);
      end
      if (b_hs >= G && b_wait < 1000) b_wait++;
      if (a_hs >= G && a_wait < 1000) a_wait++;
      b_tap_done = b_done_en && (b_wait > b_delay);
      a_tap_done = a_done_en && (a_wait > a_delay);
    end
    b_stall  = b_tap_valid && !b_tap_ready;
    a_stall  = a_tap_valid && !a_tap_ready;
    prev_en  = iir_enable;
    prev_err = load_error;
  end

  task automatic drive(input bit wr, input logic [2:0] addr,
                       input float_t d, input bit commit,
                       input bit accept);
    @(negedge clk);
    cfg_wr_en   = wr;
    cfg_wr_addr = addr;
    cfg_wr_data = d;
    cfg_commit  = commit;
    #1;
    if (wr && accept) begin
      if (int'(addr) < G) mdl_b[int'(addr)] = d;
      else if (int'(addr) < 2 * G) mdl_a[int'(addr) - G] = d;
    end
    if (commit)
      for (int i = 0; i < G; i++) begin
        exp_b.push_back(mdl_b[i]);
        exp_a.push_back(mdl_a[i]);
      end
    @(negedge clk);
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    #1;
  endtask

  task automatic commit_chk();
    drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
    chk("commit_busy", 32'(cfg_busy), 1);
    chk("commit_enable", 32'(iir_enable), 0);
    chk("commit_flags",
        32'({cfg_loaded, load_error, cfg_wr_dropped}), 0);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cfg_busy) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) begin
      checks++; errs++;
      $display("FAIL %s_wait: busy=1 expected 0", nm);
    end
  endtask

  task automatic wait_stream();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_busy && iir_enable) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) begin
      checks++; errs++;
      $display("FAIL stream_wait: enable=0 expected 1");
    end
  endtask

  task automatic done_ok(input string nm);
    chk({nm, "_loaded"}, 32'(cfg_loaded), 1);
    chk({nm, "_busy"}, 32'(cfg_busy), 0);
    chk({nm, "_error"}, 32'(load_error), 0);
    chk({nm, "_b_hs"}, b_hs, G);
    chk({nm, "_a_hs"}, a_hs, G);
    chk({nm, "_q_left"}, exp_b.size() + exp_a.size(), 0);
  endtask

  task automatic reset_tb();
    exp_b.delete();
    exp_a.delete();
    b_hs = 0; a_hs = 0; b_wait = 0; a_wait = 0;
    flush_cyc = 0; since_stream = 0;
    b_tap_done = 1'b0; a_tap_done = 1'b0;
    for (int i = 0; i < G; i++) begin
      mdl_b[i] = '0;
      mdl_a[i] = '0;
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctrl"}, 32'({cfg_busy, cfg_loaded, cfg_wr_dropped,
        load_error, iir_enable, b_tap_valid, a_tap_valid}), 0);
    chk({nm, "_b_tap"}, b_tap, 0);
    chk({nm, "_a_tap"}, a_tap, 0);
  endtask

  initial begin
    reset_tb();
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b0;

    // Happy path; the final a-tap write shares the commit cycle.
    drive(1'b1, 3'd0, 32'h3F800000, 1'b0, 1'b1);
    drive(1'b1, 3'd1, 32'h3F000000, 1'b0, 1'b1);
    drive(1'b1, 3'd2, 32'h3E800000, 1'b0, 1'b1);
    drive(1'b1, 3'd3, 32'h3F800000, 1'b0, 1'b1);
    drive(1'b1, 3'd4, 32'hBF000000, 1'b0, 1'b1);
    drive(1'b1, 3'd6, 32'hDEADBEEF, 1'b0, 1'b0);
    drive(1'b1, 3'd7, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("oob_no_drop", 32'(cfg_wr_dropped), 0);
    drive(1'b1, 3'd5, 32'h3DCCCCCD, 1'b1, 1'b1);
    chk("commit_busy", 32'(cfg_busy), 1);
    chk("commit_enable", 32'(iir_enable), 0);
    wait_idle("happy");
    done_ok("happy");

    // Backpressure on a: ready 1,0,0,1,0,1.
    a_pat = 8'hE9; b_delay = 0; a_delay = 0;
    commit_chk();
    wait_idle("bp");
    done_ok("bp");
    chk("bp_a_after_b", 32'(a_last_t > b_last_t), 1);
    a_pat = 8'hFF; b_delay = 2; a_delay = 2;

    // Write while busy is dropped and sticky until the next commit.
    commit_chk();
    wait_stream();
    drive(1'b1, 3'd0, 32'h40000000, 1'b0, 1'b0);
    chk("drop_flag", 32'(cfg_wr_dropped), 1);
    wait_idle("drop");
    done_ok("drop");
    chk("drop_sticky", 32'(cfg_wr_dropped), 1);
    commit_chk();
    wait_idle("drop2");
    done_ok("drop2");

    // Pending commit restarts right after the first load.
    commit_chk();
    wait_stream();
    drive(1'b0, 3'd0, '0, 1'b1, 1'b0);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (cfg_loaded) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errs++;
        $display("FAIL pend_loaded: loaded=0 expected 1");
      end
    end
    @(negedge clk);
    #1;
    chk("pend_refl_busy", 32'(cfg_busy), 1);
    chk("pend_refl_en", 32'(iir_enable), 0);
    chk("pend_refl_loaded", 32'(cfg_loaded), 0);
    wait_idle("pend");
    done_ok("pend");

    // Timeout with b done never raised.
    b_done_en = 1'b0;
    commit_chk();
    wait_idle("tmo");
    chk("tmo_error", 32'(load_error), 1);
    chk("tmo_loaded_end", 32'(cfg_loaded), 0);
    chk("tmo_q_left", exp_b.size() + exp_a.size(), 0);
    b_done_en = 1'b1;
    commit_chk();
    wait_idle("recover");
    done_ok("recover");

    // Reset after the first b handshake; shadows return to zero.
    commit_chk();
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk);
        #1;
        if (b_hs >= 1) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errs++;
        $display("FAIL rst_hs_wait: b_hs=%0d expected 1", b_hs);
      end
    end
    reset = 1'b1;
    reset_tb();
    repeat (2) @(negedge clk);
    chk_reset_outs("mid_rst");
    reset = 1'b0;
    commit_chk();
    wait_idle("post_rst");
    done_ok("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/iir_tap_loader.md
Name: iir_tap_loader

Overview:
- Initiator side of the IIR tap-programming interface.
- Holds shadow copies of G_DEGREE b-taps and G_DEGREE a-taps (IEEE-754 float32), written by a simple config write port.
- On a commit it drops the filter's enable to flush its state, re-enables it, and streams both tap sets over independent valid/ready channels.
- It then waits for both done flags and reports load status; it sits between the control-register block and each IIR floating-point filter instance.

Parameters:
- G_DEGREE, 3: taps per set; must match the attached filter.
- ENABLE_LOW_CYCLES, 2: cycles iir_enable is held low before streaming; minimum 1.
- DONE_TIMEOUT, 64: cycles allowed from STREAM entry until both done flags are seen.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_wr_en  in  1  shadow write strobe
- cfg_wr_addr  in  $clog2(2*G_DEGREE)  0..G-1 = b[i], G..2G-1 = a[i-G]
- cfg_wr_data  in  32  float32 tap value
- cfg_commit  in  1  single-cycle pulse that starts a load
- cfg_busy  out  1  load in progress
- cfg_loaded  out  1  last load completed successfully
- cfg_wr_dropped  out  1  sticky: a write arrived while busy
- load_error  out  1  sticky: done timeout occurred
- iir_enable  out  1  drives filter enable
- b_tap  out  32  b-tap data
- b_tap_valid  out  1
- b_tap_ready  in  1
- b_tap_done  in  1
- a_tap  out  32  a-tap data
- a_tap_valid  out  1
- a_tap_ready  in  1
- a_tap_done  in  1

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. All outputs are 0, state is IDLE, shadow registers are 0, the pending-commit flag is clear, all counters are 0.
- The filter stays disabled (iir_enable=0) until the first commit.
- Shadow writes:
  - Accepted only in IDLE.
  - Out-of-range addresses are ignored with no flag.
  - A write while busy is dropped and sets cfg_wr_dropped.
- States and transitions:
  - IDLE:
    - cfg_commit → FLUSH on the next edge.
    - On that edge: iir_enable=0, cfg_busy=1, cfg_loaded=0, load_error=0, cfg_wr_dropped=0.
    - A write and a commit in the same cycle: the write is applied first and the new value is streamed.
  - FLUSH:
    - Counts ENABLE_LOW_CYCLES cycles, then → STREAM.
    - On that edge: iir_enable=1, b_tap_valid=1, a_tap_valid=1, both indices 0, b_tap=shadow_b[0], a_tap=shadow_a[0].
  - STREAM:
    - The b and a channels run independently.
    - On valid&&ready: index+1 and the data register updates to the next tap on the same edge.
    - After the handshake of index G-1, that channel's valid drops to 0 and data holds.
    - Valid is never withdrawn before its handshake completes.
    - Data stays stable while valid && !ready.
    - When both channels have finished → WAIT_DONE.
  - WAIT_DONE:
    - b_tap_done && a_tap_done → IDLE, with cfg_busy=0 and cfg_loaded=1.
- Timeout:
  - A cycle counter starts at STREAM entry and runs in STREAM and WAIT_DONE.
  - When it reaches DONE_TIMEOUT before both done flags: load_error=1, iir_enable=0, both valids=0, cfg_busy=0, cfg_loaded=0, → IDLE.
- Pending commit:
  - A cfg_commit while busy sets the pending flag (one deep; further commits are merged).
  - On return to IDLE with pending set, the next cycle behaves as a commit in IDLE and the flag clears.
- Reset mid-load: returns everything to reset values; the filter sees enable=0 and reinitialises.
- The loader produces no data path latency. Minimum load time from commit to cfg_loaded = 1 + ENABLE_LOW_CYCLES + G_DEGREE + filter done latency.

Optional Feature:
- Macro: IIR_TAP_LOADER_READBACK_EN.
- When defined:
  - Adds ports cfg_rd_en (in, 1), cfg_rd_addr (in, same width as cfg_wr_addr), cfg_rd_data (out, 32), cfg_rd_valid (out, 1).
  - A read returns the shadow value one cycle later with cfg_rd_valid pulsed; an out-of-range address returns 0.
  - Reads are allowed in any state.
  - A read and a write to the same address in the same cycle return the old value.
- When undefined: the ports are absent and there is no readback logic.

Decomposition:
- Package iir_tap_loader_pkg:
  - float_t (logic [31:0]).
  - State enum: ST_IDLE, ST_FLUSH, ST_STREAM, ST_WAIT_DONE.
  - Address helper functions for the b/a split.
- Sub-module tap_stream_channel:
  - Contains the index counter, valid register, data mux and finished flag.
  - Instantiated twice, once for b and once for a.
  - Inputs: start, the tap array, ready. Outputs: data, valid, finished.

Test Plan (G_DEGREE=3):
- Happy path:
  - Stimulus: write b = 1.0, 0.5, 0.25 (0x3F800000, 0x3F000000, 0x3E800000) and a = 1.0, -0.5, 0.1; commit; responder always ready; done 2 cycles after the last handshake.
  - Response: iir_enable low for 2 cycles, each channel streams exactly 3 values in order, cfg_loaded=1, cfg_busy=0.
- Backpressure:
  - Stimulus: a_tap_ready toggled 1,0,0,1,0,1; b_tap_ready held 1.
  - Response: a_tap stable while stalled, a channel finishes after b, WAIT_DONE is entered only after both finish.
- Write while busy:
  - Stimulus: write addr 0 = 0x40000000 during STREAM.
  - Response: cfg_wr_dropped=1 and shadow b[0] unchanged; the next commit clears the flag.
- Pending commit:
  - Stimulus: commit during STREAM.
  - Response: after cfg_loaded, a second FLUSH starts the following cycle and the taps are streamed twice.
- Timeout:
  - Stimulus: DONE_TIMEOUT=8, b_tap_done never asserted.
  - Response: load_error=1, iir_enable=0, cfg_loaded=0 at cycle 8 after STREAM entry.
- Reset mid-stream:
  - Stimulus: reset after one b handshake.
  - Response: all outputs 0; a fresh commit streams from index 0.
